store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer.sv | 148 ++++++++++++++
 tb/tb_store_buffer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Store buffer between the MEM stage and data memory: formats sb/sh/sw stores into
// word-aligned byte-lane writes and queues them in a DEPTH-entry FIFO.
// Optional macro STORE_MISALIGN_TRAP_EN adds misaligned-store detection and the misalign port.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [2:0]  st_funct3,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic        buf_empty
`ifdef STORE_MISALIGN_TRAP_EN
    ,
    output logic        misalign
`endif
);

    // Both ports use valid/ready: a transfer happens on a rising edge where valid && ready;
    // ready never depends on valid, and a producer holding valid keeps its payload stable.

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    logic [CW-1:0] count;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic [29:0]   entry_addr  [DEPTH];
    logic [31:0]   entry_wdata [DEPTH];
    logic [3:0]    entry_wstrb [DEPTH];

    logic [31:0]   fmt_wdata;
    logic [3:0]    fmt_wstrb;
    logic          fmt_legal;
`ifdef STORE_MISALIGN_TRAP_EN
    logic          fmt_misaligned;
`endif

    logic          accept;
    logic          push;
    logic          pop;

    // Lane formatting: data is replicated across lanes so the strobe alone selects bytes.
    always_comb begin
        fmt_wdata = '0;
        fmt_wstrb = '0;
        fmt_legal = 1'b0;
`ifdef STORE_MISALIGN_TRAP_EN
        fmt_misaligned = 1'b0;
`endif
        case (st_funct3)
            F3_SB: begin
                fmt_wdata = {4{st_data[7:0]}};
                fmt_wstrb = 4'b0001 << st_addr[1:0];
                fmt_legal = 1'b1;
            end
            F3_SH: begin
                fmt_wdata = {2{st_data[15:0]}};
                fmt_wstrb = st_addr[1] ? 4'b1100 : 4'b0011;
                fmt_legal = 1'b1;
`ifdef STORE_MISALIGN_TRAP_EN
                fmt_misaligned = st_addr[0];
`endif
            end
            F3_SW: begin
                fmt_wdata = st_data;
                fmt_wstrb = 4'b1111;
                fmt_legal = 1'b1;
`ifdef STORE_MISALIGN_TRAP_EN
                fmt_misaligned = (st_addr[1:0] != 2'b00);
`endif
            end
            default: begin
                fmt_wdata = '0;
                fmt_wstrb = '0;
                fmt_legal = 1'b0;
            end
        endcase
    end

    // Illegal widths (and misaligned stores when trapping) complete the handshake but push nothing.
    assign st_ready  = (count != CW'(DEPTH));
    assign accept    = st_valid && st_ready;
`ifdef STORE_MISALIGN_TRAP_EN
    assign push      = accept && fmt_legal && !fmt_misaligned;
`else
    assign push      = accept && fmt_legal;
`endif
    assign mem_valid = (count != '0);
    assign pop       = mem_valid && mem_ready;
    assign buf_empty = (count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Entry storage needs no reset: it is only observed through the count-gated outputs.
    always_ff @(posedge clk) begin
        if (push) begin
            entry_addr[wr_ptr]  <= st_addr[31:2];
            entry_wdata[wr_ptr] <= fmt_wdata;
            entry_wstrb[wr_ptr] <= fmt_wstrb;
        end
    end

`ifdef STORE_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign <= 1'b0;
        end else begin
            misalign <= accept && fmt_legal && fmt_misaligned;
        end
    end
`endif

    assign mem_addr  = mem_valid ? {entry_addr[rd_ptr], 2'b00} : '0;
    assign mem_wdata = mem_valid ? entry_wdata[rd_ptr] : '0;
    assign mem_wstrb = mem_valid ? entry_wstrb[rd_ptr] : '0;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: table of single-store formatting vectors plus
// hand-written full/stall, push-while-pop and mid-operation reset sequences.
module tb_store_buffer;

    logic        clk;
    logic        rst;
    logic        st_valid;
    logic        st_ready;
    logic [2:0]  st_funct3;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        buf_empty;
`ifdef STORE_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    int errors;
    int checks;

    logic [67:0] exp_q[$];

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] data;
        logic        push;
        logic [31:0] eaddr;
        logic [31:0] ewdata;
        logic [3:0]  ewstrb;
        logic        mis;
    } vec_t;

    vec_t vecs[11];

    store_buffer #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_funct3 (st_funct3),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .buf_empty (buf_empty)
`ifdef STORE_MISALIGN_TRAP_EN
        ,
        .misalign  (misalign)
`endif
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [67:0] mem_word();
        return {mem_addr, mem_wdata, mem_wstrb};
    endfunction

    // Driver tasks
    task automatic drive_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        st_valid  = 1'b1;
        st_funct3 = f3;
        st_addr   = a;
        st_data   = d;
    endtask

    task automatic drive_idle();
        st_valid  = 1'b0;
        st_funct3 = 3'b000;
        st_addr   = '0;
        st_data   = '0;
    endtask

    // Push one sw store with mem_ready low and record it in the scoreboard.
    task automatic push_sw(input logic [31:0] a, input logic [31:0] d);
        drive_store(3'b010, a, d);
        step();
        drive_idle();
        exp_q.push_back({a, d, 4'b1111});
    endtask

    // Drain the scoreboard with mem_ready high, checking one entry per cycle.
    task automatic drain(input string name);
        mem_ready = 1'b1;
        while (exp_q.size() != 0) begin
            check({name, "_valid"}, {67'd0, mem_valid}, 68'd1);
            check({name, "_entry"}, mem_word(), exp_q.pop_front());
            step();
        end
        mem_ready = 1'b0;
        check({name, "_empty"}, {67'd0, buf_empty}, 68'd1);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        mem_ready = 1'b0;
        drive_idle();

        vecs[0]  = '{3'b000, 32'h0000_1003, 32'hAABB_CCDD, 1'b1, 32'h0000_1000, 32'hDDDD_DDDD, 4'b1000, 1'b0};
        vecs[1]  = '{3'b000, 32'h0000_1000, 32'hAABB_CCDD, 1'b1, 32'h0000_1000, 32'hDDDD_DDDD, 4'b0001, 1'b0};
        vecs[2]  = '{3'b000, 32'h0000_1001, 32'h0000_0011, 1'b1, 32'h0000_1000, 32'h1111_1111, 4'b0010, 1'b0};
        vecs[3]  = '{3'b001, 32'h0000_2002, 32'h1234_5678, 1'b1, 32'h0000_2000, 32'h5678_5678, 4'b1100, 1'b0};
        vecs[4]  = '{3'b001, 32'h0000_2000, 32'h0000_BEEF, 1'b1, 32'h0000_2000, 32'hBEEF_BEEF, 4'b0011, 1'b0};
        vecs[5]  = '{3'b010, 32'h0000_4000, 32'hDEAD_BEEF, 1'b1, 32'h0000_4000, 32'hDEAD_BEEF, 4'b1111, 1'b0};
        vecs[6]  = '{3'b011, 32'h0000_5000, 32'h1111_2222, 1'b0, 32'h0,         32'h0,         4'b0000, 1'b0};
        vecs[7]  = '{3'b111, 32'h0000_5004, 32'h3333_4444, 1'b0, 32'h0,         32'h0,         4'b0000, 1'b0};
`ifdef STORE_MISALIGN_TRAP_EN
        vecs[8]  = '{3'b010, 32'h0000_3001, 32'hCAFE_F00D, 1'b0, 32'h0,         32'h0,         4'b0000, 1'b1};
        vecs[9]  = '{3'b001, 32'h0000_2003, 32'h0000_A55A, 1'b0, 32'h0,         32'h0,         4'b0000, 1'b1};
`else
        vecs[8]  = '{3'b010, 32'h0000_3001, 32'hCAFE_F00D, 1'b1, 32'h0000_3000, 32'hCAFE_F00D, 4'b1111, 1'b0};
        vecs[9]  = '{3'b001, 32'h0000_2003, 32'h0000_A55A, 1'b1, 32'h0000_2000, 32'hA55A_A55A, 4'b1100, 1'b0};
`endif
        vecs[10] = '{3'b010, 32'h0000_6004, 32'h0123_4567, 1'b1, 32'h0000_6004, 32'h0123_4567, 4'b1111, 1'b0};

        step();
        step();
        check("rst_mem_valid", {67'd0, mem_valid}, 68'd0);
        check("rst_buf_empty", {67'd0, buf_empty}, 68'd1);
        check("rst_st_ready",  {67'd0, st_ready},  68'd1);
        check("rst_mem_word",  mem_word(),         68'd0);
`ifdef STORE_MISALIGN_TRAP_EN
        check("rst_misalign",  {67'd0, misalign},  68'd0);
`endif
        rst = 1'b0;
        step();

        // Table-driven single-store formatting, latency and stall stability
        for (int i = 0; i < 11; i++) begin
            mem_ready = 1'b0;
            drive_store(vecs[i].f3, vecs[i].addr, vecs[i].data);
            check($sformatf("v%0d_ready", i), {67'd0, st_ready}, 68'd1);
            check($sformatf("v%0d_no_bypass", i), {67'd0, mem_valid}, 68'd0);
            step();
            drive_idle();
            check($sformatf("v%0d_valid", i), {67'd0, mem_valid}, {67'd0, vecs[i].push});
            check($sformatf("v%0d_empty", i), {67'd0, buf_empty}, {67'd0, !vecs[i].push});
            check($sformatf("v%0d_word", i), mem_word(), {vecs[i].eaddr, vecs[i].ewdata, vecs[i].ewstrb});
`ifdef STORE_MISALIGN_TRAP_EN
            check($sformatf("v%0d_mis", i), {67'd0, misalign}, {67'd0, vecs[i].mis});
`endif
            step();
            check($sformatf("v%0d_hold", i), mem_word(), {vecs[i].eaddr, vecs[i].ewdata, vecs[i].ewstrb});
`ifdef STORE_MISALIGN_TRAP_EN
            check($sformatf("v%0d_mis_pulse", i), {67'd0, misalign}, 68'd0);
`endif
            mem_ready = 1'b1;
            step();
            mem_ready = 1'b0;
            check($sformatf("v%0d_popped", i), {67'd0, buf_empty}, 68'd1);
        end

        // Fill to DEPTH under stall, check backpressure and stability, then drain in order
        push_sw(32'h0000_7000, 32'hA000_0001);
        push_sw(32'h0000_7004, 32'hB000_0002);
        push_sw(32'h0000_7008, 32'hC000_0003);
        check("fill3_ready", {67'd0, st_ready}, 68'd1);
        push_sw(32'h0000_700C, 32'hD000_0004);
        check("full_ready", {67'd0, st_ready}, 68'd0);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("full_hold%0d", k), mem_word(), exp_q[0]);
            step();
        end
        drain("drain_full");

        // Full buffer: a pop does not open st_ready in the same cycle; then push+pop at count 3
        push_sw(32'h0000_8000, 32'h0000_00A1);
        push_sw(32'h0000_8004, 32'h0000_00B2);
        push_sw(32'h0000_8008, 32'h0000_00C3);
        push_sw(32'h0000_800C, 32'h0000_00D4);
        drive_store(3'b010, 32'h0000_8010, 32'h0000_00E5);
        mem_ready = 1'b1;
        check("pp_full_ready", {67'd0, st_ready}, 68'd0);
        check("pp_pop0", mem_word(), exp_q.pop_front());
        step();
        check("pp_ready_after_pop", {67'd0, st_ready}, 68'd1);
        check("pp_pop1", mem_word(), exp_q.pop_front());
        exp_q.push_back({32'h0000_8010, 32'h0000_00E5, 4'b1111});
        step();
        drive_idle();
        mem_ready = 1'b0;
        check("pp_count3_ready", {67'd0, st_ready}, 68'd1);
        check("pp_front", mem_word(), exp_q[0]);
        drain("drain_pp");

        // Reset mid-operation with a stalled head entry
        push_sw(32'h0000_9000, 32'h1111_1111);
        push_sw(32'h0000_9004, 32'h2222_2222);
        push_sw(32'h0000_9008, 32'h3333_3333);
        exp_q.delete();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mrst_valid", {67'd0, mem_valid}, 68'd0);
        check("mrst_empty", {67'd0, buf_empty}, 68'd1);
        check("mrst_word",  mem_word(),         68'd0);
        check("mrst_ready", {67'd0, st_ready},  68'd1);
        drive_store(3'b000, 32'h0000_A002, 32'h0000_0077);
        step();
        drive_idle();
        exp_q.push_back({32'h0000_A000, 32'h7777_7777, 4'b0100});
        drain("drain_after_rst");

        // Final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
